dmem_port_arbiter: RTL

Shares the single-port data memory between the processor's load/store port and one auxiliary requester, such as the game-board scanner or the input writer. The processor has priority in every cycle it accesses memory. The auxiliary requester is served in the free cycles, through a request/grant handshake with registered read return. The block sits between the processor's dmem outputs and the dmem instance; the memory pins connect only to this block.

---
 rtl/dmem_port_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares single-port dmem between the processor (priority, combinational path) and one aux requester (grant 0+ cycles, read data 2 cycles after grant).
// Aux holds v_req until v_gnt; with DMEM_ARB_STARVE_EN a starved request forces a one-cycle processor stall via p_stall.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_en,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic [DATA_W-1:0] p_q,
    output logic              p_stall,
    input  logic              v_req,
    input  logic              v_wren,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [DATA_W-1:0] v_data,
    output logic              v_gnt,
    output logic              v_rvalid,
    output logic [DATA_W-1:0] v_q,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data,
    output logic              m_wren,
    input  logic [DATA_W-1:0] m_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FORCE = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_port_arbiter: STARVE_LIMIT must be within 1..255");
    end

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_force;
    logic              w_gnt;
    logic              r_pend;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_vq;

    assign w_gnt = v_req & (~p_en | w_force);

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    assign w_force = (r_state == S_FORCE);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (v_req && p_en) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd1;
                end
            end
            S_WAIT: begin
                // A dropped request is a protocol error; recover quietly.
                if (w_gnt || !v_req) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = 8'd0;
                end else if (r_wait_cnt >= LIMIT) begin
                    w_state_nxt = S_FORCE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end
`else
    assign w_force = 1'b0;

    // IDLE/WAIT kept only as request status; nothing is forced.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (v_req && p_en) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_gnt || !v_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // dmem reads are registered, so q for a grant in N is valid in N+1.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend   <= 1'b0;
            r_rvalid <= 1'b0;
            r_vq     <= '0;
        end else begin
            r_pend   <= w_gnt & ~v_wren;
            r_rvalid <= r_pend;
            if (r_pend) begin
                r_vq <= m_q;
            end
        end
    end

    assign m_address = w_gnt ? v_addr : p_addr;
    assign m_data    = w_gnt ? v_data : p_data;
    assign m_wren    = w_gnt ? v_wren : (p_en & p_wren);

    assign p_q      = m_q;
    assign p_stall  = w_force;
    assign v_gnt    = w_gnt;
    assign v_rvalid = r_rvalid;
    assign v_q      = r_vq;

endmodule
